// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve unit: funct3 compares, kind codes,
// BHT counter type and index-width helper.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        KIND_BR   = 2'b00,
        KIND_JAL  = 2'b01,
        KIND_JALR = 2'b10,
        KIND_RSVD = 2'b11
    } kind_e;

    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_RST = 2'b01;

    function automatic int bht_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters indexed by pc[IW+1:2].
// Lookup reads the registered array, so a same-cycle update is not visible.
module branch_bht
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int IW = bht_idx_w(DEPTH);

    ctr_t          ctrs [DEPTH];
    logic [IW-1:0] lidx;
    logic [IW-1:0] uidx;
    logic          unused_bits;

    assign lidx         = lookup_pc[IW+1:2];
    assign uidx         = upd_pc[IW+1:2];
    assign lookup_taken = ctrs[lidx][1];
    assign unused_bits  = ^{lookup_pc[XLEN-1:IW+2], lookup_pc[1:0],
                            upd_pc[XLEN-1:IW+2], upd_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ctrs[i] <= CTR_RST;
        end else if (upd_en) begin
            if (upd_taken && ctrs[uidx] != 2'b11)
                ctrs[uidx] <= ctrs[uidx] + 2'd1;
            else if (!upd_taken && ctrs[uidx] != 2'b00)
                ctrs[uidx] <= ctrs[uidx] - 2'd1;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/JAL/JALR resolution with one registered valid/ready output stage.
// Define BRU_BHT_EN to add the branch history table predictor.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_op1,
    input  logic [XLEN-1:0] in_op2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_fu3,
    input  logic [1:0]      in_kind,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_link,
    output logic            out_mispredict,
    output logic            out_illegal,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken
);

    kind_e           kind;
    logic            accept;
    logic            cmp_taken;
    logic            fu3_bad;
    logic            taken;
    logic            illegal;
    logic [XLEN-1:0] target;

    assign kind     = kind_e'(in_kind);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cmp_taken = 1'b0;
        fu3_bad   = 1'b0;
        case (in_fu3)
            F3_BEQ:  cmp_taken = (in_op1 == in_op2);
            F3_BNE:  cmp_taken = (in_op1 != in_op2);
            F3_BLT:  cmp_taken = ($signed(in_op1) <  $signed(in_op2));
            F3_BGE:  cmp_taken = ($signed(in_op1) >= $signed(in_op2));
            F3_BLTU: cmp_taken = (in_op1 <  in_op2);
            F3_BGEU: cmp_taken = (in_op1 >= in_op2);
            default: fu3_bad   = 1'b1;
        endcase
    end

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        target  = in_pc + in_imm;
        case (kind)
            KIND_BR: begin
                illegal = fu3_bad;
                taken   = cmp_taken && !fu3_bad;
            end
            KIND_JAL:  taken = 1'b1;
            KIND_JALR: begin
                taken  = 1'b1;
                target = (in_op1 + in_imm) & ~XLEN'(1);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Fields only load on accept, so they stay frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_link       <= '0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_taken      <= taken;
            out_target     <= target;
            out_link       <= in_pc + XLEN'(4);
            out_mispredict <= taken != in_pred_taken;
            out_illegal    <= illegal;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

`ifdef BRU_BHT_EN
    branch_bht #(
        .XLEN  (XLEN),
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (lookup_pc),
        .lookup_taken (lookup_taken),
        .upd_en       (accept && kind == KIND_BR && !fu3_bad),
        .upd_pc       (in_pc),
        .upd_taken    (cmp_taken)
    );
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_pc;
    assign lookup_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; BHT checks follow BRU_BHT_EN.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0, in_op1 = '0, in_op2 = '0, in_imm = '0;
    logic [2:0]  in_fu3 = '0;
    logic [1:0]  in_kind = '0;
    logic        in_pred_taken = 1'b0;
    logic        out_valid, out_ready = 1'b1, out_taken, out_mispredict, out_illegal;
    logic [31:0] out_target, out_link;
    logic [31:0] lookup_pc = '0;
    logic        lookup_taken;
    int          tests = 0, failed = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op1(in_op1), .in_op2(in_op2), .in_imm(in_imm),
        .in_fu3(in_fu3), .in_kind(in_kind), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .out_link(out_link), .out_mispredict(out_mispredict),
        .out_illegal(out_illegal), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic [1:0] k, input logic [2:0] f, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic pred);
        in_kind = k; in_fu3 = f; in_pc = pc; in_op1 = a; in_op2 = b; in_imm = imm;
        in_pred_taken = pred;
    endtask

    task automatic send(input logic [1:0] k, input logic [2:0] f, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic pred);
        set_req(k, f, pc, a, b, imm, pred);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_valid got %0h exp 0", out_valid); end
        tests++; if (out_taken !== 1'b0) begin failed++; $display("FAIL rst_taken got %0h exp 0", out_taken); end
        tests++; if (out_target !== 32'h0) begin failed++; $display("FAIL rst_target got %08h exp 0", out_target); end
        tests++; if (out_link !== 32'h0) begin failed++; $display("FAIL rst_link got %08h exp 0", out_link); end
        tests++; if (out_mispredict !== 1'b0 || out_illegal !== 1'b0) begin failed++; $display("FAIL rst_flags got %0h%0h exp 00", out_mispredict, out_illegal); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_in_ready got %0h exp 1", in_ready); end
        rst = 1'b0; tick();
    endtask

    task automatic test_beq();
        out_ready = 1'b1;
        send(2'b00, 3'b000, 32'h200, 32'd5, 32'd5, 32'h10, 1'b0);
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL beq_valid got %0h exp 1", out_valid); end
        tests++; if (out_taken !== 1'b1) begin failed++; $display("FAIL beq_taken got %0h exp 1", out_taken); end
        tests++; if (out_target !== 32'h210) begin failed++; $display("FAIL beq_target got %08h exp 00000210", out_target); end
        tests++; if (out_link !== 32'h204) begin failed++; $display("FAIL beq_link got %08h exp 00000204", out_link); end
        tests++; if (out_mispredict !== 1'b1) begin failed++; $display("FAIL beq_mispredict got %0h exp 1", out_mispredict); end
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL beq_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_compare();
        logic [2:0]  f  [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b000, 3'b001, 3'b100};
        logic [31:0] a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd3, 32'd3, 32'd3, 32'h8000_0000};
        logic [31:0] b  [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd3, 32'd4, 32'd4, 32'h7FFF_FFFF};
        logic        ex [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            send(2'b00, f[i], 32'h1000, a[i], b[i], 32'h8, 1'b1);
            tests++; if (out_taken !== ex[i]) begin failed++; $display("FAIL cmp%0d_taken got %0h exp %0h", i, out_taken, ex[i]); end
            tests++; if (out_mispredict !== !ex[i]) begin failed++; $display("FAIL cmp%0d_mispredict got %0h exp %0h", i, out_mispredict, !ex[i]); end
        end
        tick();
    endtask

    task automatic test_jump();
        send(2'b10, 3'b000, 32'h100, 32'h1001, 32'h0, 32'h2, 1'b1);
        tests++; if (out_target !== 32'h1002) begin failed++; $display("FAIL jalr_target got %08h exp 00001002", out_target); end
        tests++; if (out_link !== 32'h104) begin failed++; $display("FAIL jalr_link got %08h exp 00000104", out_link); end
        tests++; if (out_taken !== 1'b1 || out_mispredict !== 1'b0) begin failed++; $display("FAIL jalr_flags got %0h%0h exp 10", out_taken, out_mispredict); end
        send(2'b01, 3'b000, 32'h100, 32'h5, 32'h6, 32'hFFFF_FFF0, 1'b0);
        tests++; if (out_target !== 32'hF0) begin failed++; $display("FAIL jal_target got %08h exp 000000f0", out_target); end
        tests++; if (out_taken !== 1'b1 || out_mispredict !== 1'b1) begin failed++; $display("FAIL jal_flags got %0h%0h exp 11", out_taken, out_mispredict); end
        send(2'b00, 3'b010, 32'h100, 32'h7, 32'h7, 32'h8, 1'b1);
        tests++; if (out_illegal !== 1'b1) begin failed++; $display("FAIL f010_illegal got %0h exp 1", out_illegal); end
        tests++; if (out_taken !== 1'b0 || out_mispredict !== 1'b1) begin failed++; $display("FAIL f010_flags got %0h%0h exp 01", out_taken, out_mispredict); end
        send(2'b11, 3'b000, 32'h100, 32'h7, 32'h7, 32'h8, 1'b0);
        tests++; if (out_illegal !== 1'b1 || out_taken !== 1'b0 || out_mispredict !== 1'b0) begin failed++; $display("FAIL kind11 got ill=%0h tk=%0h mp=%0h exp 1 0 0", out_illegal, out_taken, out_mispredict); end
        send(2'b01, 3'b011, 32'h100, 32'h7, 32'h7, 32'h8, 1'b1);
        tests++; if (out_illegal !== 1'b0 || out_taken !== 1'b1) begin failed++; $display("FAIL jal_f011 got ill=%0h tk=%0h exp 0 1", out_illegal, out_taken); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(2'b00, 3'b000, 32'h300, 32'd9, 32'd9, 32'h8, 1'b1);
        set_req(2'b00, 3'b001, 32'h400, 32'd1, 32'd2, 32'h20, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL stall%0d_in_ready got %0h exp 0", c, in_ready); end
            tests++; if (out_valid !== 1'b1 || out_target !== 32'h308 || out_link !== 32'h304) begin failed++; $display("FAIL stall%0d_hold got v=%0h t=%08h l=%08h exp 1 308 304", c, out_valid, out_target, out_link); end
            tick();
        end
        out_ready = 1'b1; #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL release_in_ready got %0h exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_target !== 32'h420 || out_mispredict !== 1'b1) begin failed++; $display("FAIL second_req got v=%0h t=%08h mp=%0h exp 1 420 1", out_valid, out_target, out_mispredict); end
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL b2b_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_bht();
`ifdef BRU_BHT_EN
        logic [1:0] k  [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [2:0] f  [9] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        logic       ex [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        lookup_pc = 32'h40;
        #1;
        tests++; if (lookup_taken !== 1'b0) begin failed++; $display("FAIL bht_init got %0h exp 0", lookup_taken); end
        // taken x3 (01->10->11->11), not-taken x4 (->10->01->00->00), JAL (no train), taken (->01)
        for (int i = 0; i < 9; i++) begin
            send(k[i], f[i], 32'h40, 32'd2, 32'd2, 32'h4, 1'b0);
            tests++; if (lookup_taken !== ex[i]) begin failed++; $display("FAIL bht_step%0d got %0h exp %0h", i, lookup_taken, ex[i]); end
        end
        lookup_pc = 32'h44; #1;
        tests++; if (lookup_taken !== 1'b0) begin failed++; $display("FAIL bht_other_idx got %0h exp 0", lookup_taken); end
        send(2'b00, 3'b000, 32'h40, 32'd2, 32'd2, 32'h4, 1'b0);
        send(2'b00, 3'b000, 32'h40, 32'd2, 32'd2, 32'h4, 1'b0);
        lookup_pc = 32'h40; #1;
        tests++; if (lookup_taken !== 1'b1) begin failed++; $display("FAIL bht_pretrain got %0h exp 1", lookup_taken); end
`else
        lookup_pc = 32'h40;
        send(2'b00, 3'b000, 32'h40, 32'd2, 32'd2, 32'h4, 1'b0);
        send(2'b00, 3'b000, 32'h40, 32'd2, 32'd2, 32'h4, 1'b0);
        tests++; if (lookup_taken !== 1'b0) begin failed++; $display("FAIL static_lookup got %0h exp 0", lookup_taken); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(2'b01, 3'b000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 1'b0);
        tests++; if (out_valid !== 1'b1 || out_link !== 32'h0 || out_target !== 32'h4) begin failed++; $display("FAIL wrap got v=%0h l=%08h t=%08h exp 1 0 4", out_valid, out_link, out_target); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if (out_valid !== 1'b0 || out_target !== 32'h0 || out_taken !== 1'b0) begin failed++; $display("FAIL mid_rst got v=%0h t=%08h tk=%0h exp 0 0 0", out_valid, out_target, out_taken); end
        out_ready = 1'b1;
`ifdef BRU_BHT_EN
        lookup_pc = 32'h40;
        send(2'b00, 3'b000, 32'h40, 32'd2, 32'd2, 32'h4, 1'b0);
        tests++; if (lookup_taken !== 1'b1) begin failed++; $display("FAIL bht_after_rst got %0h exp 1", lookup_taken); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_compare();
        test_jump();
        test_back_to_back();
        test_bht();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
